// File: rtl/note_seq_pkg.sv
// Package: note_seq_pkg
// Shared types and constants for the note sequencer.
//   state_t            : sequencer FSM states
//   FCW_WIDTH_DEFAULT  : default NCO phase accumulator width
//   FREQ_*_CHZ         : note frequencies in centi-hertz, so integer math keeps two decimals
//   calc_fcw()         : round(f * 2^width / clock_hz), evaluated at elaboration time
package note_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ECHO,
    PLAY,
    GAP
  } state_t;

  localparam int FCW_WIDTH_DEFAULT = 24;

  localparam longint FREQ_C4_CHZ = 26163;
  localparam longint FREQ_D4_CHZ = 29366;
  localparam longint FREQ_E4_CHZ = 32963;
  localparam longint FREQ_F4_CHZ = 34923;
  localparam longint FREQ_G4_CHZ = 39200;
  localparam longint FREQ_A4_CHZ = 44000;
  localparam longint FREQ_B4_CHZ = 49388;
  localparam longint FREQ_C5_CHZ = 52325;

  // Frequencies are in centi-hertz, so the divisor carries the matching factor of 100.
  function automatic longint calc_fcw(input longint freq_chz, input longint clock_hz,
                                      input int width);
    longint num;
    longint den;
    num = freq_chz * (longint'(1) << width);
    den = clock_hz * 100;
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/note_fcw_rom.sv
// Module: note_fcw_rom
// Combinational keyboard-character to NCO frequency control word lookup.
// Ports:
//   char_code  in   8          ASCII byte to look up
//   mapped     out  1          high when char_code is one of the eight note keys
//   fcw        out  FCW_WIDTH  frequency control word; 0 when unmapped
module note_fcw_rom
  import note_seq_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int FCW_WIDTH  = FCW_WIDTH_DEFAULT
) (
  input  logic [7:0]           char_code,
  output logic                 mapped,
  output logic [FCW_WIDTH-1:0] fcw
);

  localparam longint CLK_HZ = longint'(CLOCK_FREQ);

  localparam logic [FCW_WIDTH-1:0] FCW_C4 = FCW_WIDTH'(calc_fcw(FREQ_C4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_D4 = FCW_WIDTH'(calc_fcw(FREQ_D4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_E4 = FCW_WIDTH'(calc_fcw(FREQ_E4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_F4 = FCW_WIDTH'(calc_fcw(FREQ_F4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_G4 = FCW_WIDTH'(calc_fcw(FREQ_G4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_A4 = FCW_WIDTH'(calc_fcw(FREQ_A4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_B4 = FCW_WIDTH'(calc_fcw(FREQ_B4_CHZ, CLK_HZ, FCW_WIDTH));
  localparam logic [FCW_WIDTH-1:0] FCW_C5 = FCW_WIDTH'(calc_fcw(FREQ_C5_CHZ, CLK_HZ, FCW_WIDTH));

  // Bottom keyboard row z..m plus ',' forms one octave; only lower-case keys play.
  always_comb begin
    mapped = 1'b1;
    fcw    = '0;
    case (char_code)
      8'h7A:   fcw = FCW_C4;
      8'h78:   fcw = FCW_D4;
      8'h63:   fcw = FCW_E4;
      8'h76:   fcw = FCW_F4;
      8'h62:   fcw = FCW_G4;
      8'h6E:   fcw = FCW_A4;
      8'h6D:   fcw = FCW_B4;
      8'h2C:   fcw = FCW_C5;
      default: mapped = 1'b0;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Module: note_sequencer
// Pulls bytes from the UART RX FIFO, echoes each one into the TX FIFO and, for
// note keys, drives the matching frequency control word onto the NCO for the
// current note length. Debounced buttons lengthen/shorten notes at run time.
// Optional feature macro: NOTE_SEQ_GAP_EN adds a silent GAP state of
// GAP_CYCLES after every note so repeated notes are articulated.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rx_fifo_*      RX FIFO read side (dout valid the cycle after rd_en)
//   tx_fifo_*      TX FIFO write side for the echo
//   len_up/down    one-cycle length adjust pulses
//   fcw, note_en   NCO control; fcw = 0 means silent
//   busy           high whenever the FSM is not IDLE
//   note_len       current note length register
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int CLOCK_FREQ        = 125_000_000,
  parameter int CYCLES_PER_SECOND = 125_000_000,
  parameter int NOTE_LEN_DEFAULT  = CYCLES_PER_SECOND / 5,
  parameter int NOTE_LEN_STEP     = CYCLES_PER_SECOND / 20,
  parameter int NOTE_LEN_MIN      = CYCLES_PER_SECOND / 20,
  parameter int NOTE_LEN_MAX      = CYCLES_PER_SECOND,
  parameter int GAP_CYCLES        = CYCLES_PER_SECOND / 50,
  parameter int FCW_WIDTH         = FCW_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_fifo_empty,
  input  logic [7:0]           rx_fifo_dout,
  output logic                 rx_fifo_rd_en,
  input  logic                 tx_fifo_full,
  output logic [7:0]           tx_fifo_din,
  output logic                 tx_fifo_wr_en,
  input  logic                 len_up,
  input  logic                 len_down,
  output logic [FCW_WIDTH-1:0] fcw,
  output logic                 note_en,
  output logic                 busy,
  output logic [31:0]          note_len
);

  localparam logic [31:0] LEN_DEFAULT = 32'(NOTE_LEN_DEFAULT);
  localparam logic [31:0] LEN_STEP    = 32'(NOTE_LEN_STEP);
  localparam logic [31:0] LEN_MIN     = 32'(NOTE_LEN_MIN);
  localparam logic [31:0] LEN_MAX     = 32'(NOTE_LEN_MAX);
  // GAP_CYCLES must be at least 1 when the gap feature is built in.
  localparam logic [31:0] GAP_LEN     = 32'(GAP_CYCLES);

  state_t                 state;
  logic [7:0]             char_q;
  logic [31:0]            cnt;
  logic                   rom_mapped;
  logic [FCW_WIDTH-1:0]   rom_fcw;

  note_fcw_rom #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .FCW_WIDTH (FCW_WIDTH)
  ) u_rom (
    .char_code(char_q),
    .mapped   (rom_mapped),
    .fcw      (rom_fcw)
  );

  // The FIFO strobes are decoded from state and the FIFO flags in the same
  // cycle, so a pop can never hit an empty FIFO and a push never a full one.
  assign rx_fifo_rd_en = (state == IDLE) && !rx_fifo_empty;
  assign tx_fifo_wr_en = (state == ECHO) && !tx_fifo_full;
  assign tx_fifo_din   = char_q;
  assign busy          = (state != IDLE);

  // cnt counts down the remaining cycles of the current PLAY (or GAP) phase;
  // leaving at cnt == 1 makes the phase last exactly its loaded length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      char_q  <= '0;
      cnt     <= '0;
      fcw     <= '0;
      note_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_fifo_empty) state <= FETCH;
        end
        FETCH: begin
          char_q <= rx_fifo_dout;
          state  <= ECHO;
        end
        ECHO: begin
          if (!tx_fifo_full) begin
            if (rom_mapped) begin
              state   <= PLAY;
              cnt     <= note_len;
              fcw     <= rom_fcw;
              note_en <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        PLAY: begin
          if (cnt == 32'd1) begin
            fcw     <= '0;
            note_en <= 1'b0;
            cnt     <= GAP_LEN;
`ifdef NOTE_SEQ_GAP_EN
            state   <= GAP;
`else
            state   <= IDLE;
`endif
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
`ifdef NOTE_SEQ_GAP_EN
        GAP: begin
          if (cnt == 32'd1) state <= IDLE;
          else              cnt   <= cnt - 32'd1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Note length adjusts in every state; a running note keeps the length it
  // copied into cnt, so presses only affect the following note.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_len <= LEN_DEFAULT;
    end else if (len_up && !len_down) begin
      note_len <= (note_len >= LEN_MAX - LEN_STEP) ? LEN_MAX : note_len + LEN_STEP;
    end else if (len_down && !len_up) begin
      note_len <= (note_len <= LEN_MIN + LEN_STEP) ? LEN_MIN : note_len - LEN_STEP;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench: tb_note_sequencer
// Drives note_sequencer through model RX/TX FIFOs. Expected echoes and notes are
// pushed to scoreboard queues as bytes are sent and compared against what the
// FIFO and NCO monitors recorded once the sequencer goes idle.
module tb_note_sequencer;

`ifdef NOTE_SEQ_GAP_EN
  localparam int EXP_GAP = 23;
`else
  localparam int EXP_GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_fifo_empty;
  logic [7:0]  rx_fifo_dout = 8'h00;
  logic        rx_fifo_rd_en;
  logic        tx_fifo_full = 1'b0;
  logic [7:0]  tx_fifo_din;
  logic        tx_fifo_wr_en;
  logic        len_up = 1'b0;
  logic        len_down = 1'b0;
  logic [23:0] fcw;
  logic        note_en;
  logic        busy;
  logic [31:0] note_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  note_sequencer #(
    .CLOCK_FREQ       (125_000_000),
    .CYCLES_PER_SECOND(1000),
    .GAP_CYCLES       (20),
    .FCW_WIDTH        (24)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_dout (rx_fifo_dout),
    .rx_fifo_rd_en(rx_fifo_rd_en),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_din  (tx_fifo_din),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .len_up       (len_up),
    .len_down     (len_down),
    .fcw          (fcw),
    .note_en      (note_en),
    .busy         (busy),
    .note_len     (note_len)
  );

  // RX FIFO model: the stimulus writes rx_mem/rx_wr, the model owns rx_rd.
  logic [7:0] rx_mem [0:63];
  int rx_wr = 0;
  int rx_rd = 0;
  int rd_pulses = 0;
  int rd_when_empty = 0;
  assign rx_fifo_empty = (rx_rd == rx_wr);

  always @(posedge clk) begin
    if (rx_fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (rx_fifo_empty) begin
        rd_when_empty <= rd_when_empty + 1;
      end else begin
        rx_fifo_dout <= rx_mem[rx_rd[5:0]];
        rx_rd <= rx_rd + 1;
      end
    end
  end

  // TX FIFO model records every echoed byte.
  logic [7:0] echo_mem [0:63];
  int echo_wr = 0;
  int wr_when_full = 0;

  always @(posedge clk) begin
    if (tx_fifo_wr_en) begin
      if (tx_fifo_full) wr_when_full <= wr_when_full + 1;
      echo_mem[echo_wr[5:0]] <= tx_fifo_din;
      echo_wr <= echo_wr + 1;
    end
  end

  // NCO monitor: records each non-zero fcw run with its length and the number
  // of silent cycles before it (-1 when no earlier note since reset).
  int note_fcw_mem [0:63];
  int note_len_mem [0:63];
  int note_gap_mem [0:63];
  int note_wr = 0;
  int note_en_cycles = 0;
  int en_mismatch = 0;
  bit in_note = 1'b0;
  bit have_prev = 1'b0;
  int cur_fcw = 0;
  int cur_len = 0;
  int cur_gap = 0;
  int silent = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_note   <= 1'b0;
      have_prev <= 1'b0;
      silent    <= 0;
    end else begin
      if (note_en !== (fcw != 24'd0)) en_mismatch <= en_mismatch + 1;
      if (note_en) note_en_cycles <= note_en_cycles + 1;
      if (fcw != 24'd0) begin
        if (!in_note) begin
          in_note <= 1'b1;
          cur_fcw <= int'(fcw);
          cur_len <= 1;
          cur_gap <= have_prev ? silent : -1;
        end else begin
          cur_len <= cur_len + 1;
        end
      end else if (in_note) begin
        note_fcw_mem[note_wr[5:0]] <= cur_fcw;
        note_len_mem[note_wr[5:0]] <= cur_len;
        note_gap_mem[note_wr[5:0]] <= cur_gap;
        note_wr   <= note_wr + 1;
        in_note   <= 1'b0;
        have_prev <= 1'b1;
        silent    <= 1;
      end else begin
        silent <= silent + 1;
      end
    end
  end

  // Scoreboard queues and read pointers, owned by the stimulus process.
  logic [7:0] exp_echo [$];
  int exp_nfcw [$];
  int exp_nlen [$];
  int exp_ngap [$];
  int echo_rd = 0;
  int note_rd = 0;

  task automatic send_char(input logic [7:0] c, input int efcw, input int elen, input int egap);
    rx_mem[rx_wr[5:0]] = c;
    rx_wr = rx_wr + 1;
    exp_echo.push_back(c);
    if (efcw != 0) begin
      exp_nfcw.push_back(efcw);
      exp_nlen.push_back(elen);
      exp_ngap.push_back(egap);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (rx_rd == rx_wr && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic press(input logic up, input logic down);
    @(posedge clk); #1;
    len_up = up;
    len_down = down;
    @(posedge clk); #1;
    len_up = 1'b0;
    len_down = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (fcw !== 24'd0) begin failures++; $display("[TB] FAIL reset_fcw got %0d required 0", fcw); end
    checks++; if (note_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_note_en got %b required 0", note_en); end
    checks++; if (tx_fifo_wr_en !== 1'b0 || rx_fifo_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes got wr=%b rd=%b required 0", tx_fifo_wr_en, rx_fifo_rd_en); end
    checks++; if (tx_fifo_din !== 8'h00) begin failures++; $display("[TB] FAIL reset_din got %h required 00", tx_fifo_din); end
    checks++; if (note_len !== 32'd200) begin failures++; $display("[TB] FAIL reset_note_len got %0d required 200", note_len); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_note;
    bit ok;
    int rp;
    int ef, el, eg;
    logic [7:0] e8;
    rp = rd_pulses;
    send_char(8'h6E, 59, 200, -1);
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (fcw !== 24'd0) begin failures++; $display("[TB] FAIL single_latency_early got fcw=%0d required 0", fcw); end
    @(posedge clk); #1;
    checks++; if (fcw !== 24'd59 || note_en !== 1'b1) begin failures++; $display("[TB] FAIL single_latency got fcw=%0d en=%b required 59/1", fcw, note_en); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL single_timeout got busy=%b required idle", busy); end
    checks++; if (fcw !== 24'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_after got fcw=%0d busy=%b required 0/0", fcw, busy); end
    checks++; if (rd_pulses - rp !== 1) begin failures++; $display("[TB] FAIL single_rd_pulses got %0d required 1", rd_pulses - rp); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL single_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL single_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
    while (exp_nfcw.size() > 0) begin
      ef = exp_nfcw.pop_front(); el = exp_nlen.pop_front(); eg = exp_ngap.pop_front();
      checks++;
      if (note_rd >= note_wr) begin failures++; $display("[TB] FAIL single_note got none required fcw=%0d", ef); end
      else begin
        if (note_fcw_mem[note_rd[5:0]] !== ef || note_len_mem[note_rd[5:0]] !== el || (eg >= 0 && note_gap_mem[note_rd[5:0]] !== eg))
          begin failures++; $display("[TB] FAIL single_note got fcw=%0d len=%0d gap=%0d required fcw=%0d len=%0d gap=%0d", note_fcw_mem[note_rd[5:0]], note_len_mem[note_rd[5:0]], note_gap_mem[note_rd[5:0]], ef, el, eg); end
        note_rd++;
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int ef, el, eg;
    logic [7:0] e8;
    send_char(8'h7A, 35, 200, -1);
    send_char(8'h78, 39, 200, EXP_GAP);
    send_char(8'h63, 44, 200, EXP_GAP);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_timeout got busy=%b required idle", busy); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL b2b_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL b2b_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
    while (exp_nfcw.size() > 0) begin
      ef = exp_nfcw.pop_front(); el = exp_nlen.pop_front(); eg = exp_ngap.pop_front();
      checks++;
      if (note_rd >= note_wr) begin failures++; $display("[TB] FAIL b2b_note got none required fcw=%0d", ef); end
      else begin
        if (note_fcw_mem[note_rd[5:0]] !== ef || note_len_mem[note_rd[5:0]] !== el || (eg >= 0 && note_gap_mem[note_rd[5:0]] !== eg))
          begin failures++; $display("[TB] FAIL b2b_note got fcw=%0d len=%0d gap=%0d required fcw=%0d len=%0d gap=%0d", note_fcw_mem[note_rd[5:0]], note_len_mem[note_rd[5:0]], note_gap_mem[note_rd[5:0]], ef, el, eg); end
        note_rd++;
      end
    end
    checks++; if (rd_when_empty !== 0 || wr_when_full !== 0) begin failures++; $display("[TB] FAIL fifo_protocol got rd_empty=%0d wr_full=%0d required 0/0", rd_when_empty, wr_when_full); end
    checks++; if (en_mismatch !== 0) begin failures++; $display("[TB] FAIL note_en_vs_fcw got %0d required 0", en_mismatch); end
  endtask

  task automatic test_unmapped;
    bit ok;
    int nc, nw;
    logic [7:0] e8;
    nc = note_en_cycles;
    nw = note_wr;
    send_char(8'h71, 0, 0, -1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL unmapped_timeout got busy=%b required idle", busy); end
    checks++; if (note_en_cycles - nc !== 0 || note_wr - nw !== 0) begin failures++; $display("[TB] FAIL unmapped_silent got en_cycles=%0d notes=%0d required 0/0", note_en_cycles - nc, note_wr - nw); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL unmapped_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL unmapped_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
  endtask

  task automatic test_tx_full;
    bit ok;
    int wr_seen, fcw_seen, ew;
    int ef, el, eg;
    logic [7:0] e8;
    wr_seen = 0;
    fcw_seen = 0;
    tx_fifo_full = 1'b1;
    ew = echo_wr;
    send_char(8'h62, 53, 200, -1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx_fifo_wr_en) wr_seen++;
      if (fcw != 24'd0) fcw_seen++;
    end
    checks++; if (wr_seen !== 0 || fcw_seen !== 0) begin failures++; $display("[TB] FAIL txfull_hold got wr=%0d fcw_cycles=%0d required 0/0", wr_seen, fcw_seen); end
    checks++; if (busy !== 1'b1 || echo_wr !== ew) begin failures++; $display("[TB] FAIL txfull_stall got busy=%b writes=%0d required 1/0", busy, echo_wr - ew); end
    tx_fifo_full = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL txfull_timeout got busy=%b required idle", busy); end
    checks++; if (echo_wr - ew !== 1) begin failures++; $display("[TB] FAIL txfull_writes got %0d required 1", echo_wr - ew); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL txfull_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL txfull_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
    while (exp_nfcw.size() > 0) begin
      ef = exp_nfcw.pop_front(); el = exp_nlen.pop_front(); eg = exp_ngap.pop_front();
      checks++;
      if (note_rd >= note_wr) begin failures++; $display("[TB] FAIL txfull_note got none required fcw=%0d", ef); end
      else begin
        if (note_fcw_mem[note_rd[5:0]] !== ef || note_len_mem[note_rd[5:0]] !== el || (eg >= 0 && note_gap_mem[note_rd[5:0]] !== eg))
          begin failures++; $display("[TB] FAIL txfull_note got fcw=%0d len=%0d required fcw=%0d len=%0d", note_fcw_mem[note_rd[5:0]], note_len_mem[note_rd[5:0]], ef, el); end
        note_rd++;
      end
    end
  endtask

  task automatic test_length;
    bit ok;
    int ef, el, eg;
    logic [7:0] e8;
    for (int i = 0; i < 20; i++) press(1'b1, 1'b0);
    checks++; if (note_len !== 32'd1000) begin failures++; $display("[TB] FAIL len_max got %0d required 1000", note_len); end
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
    checks++; if (note_len !== 32'd50) begin failures++; $display("[TB] FAIL len_min got %0d required 50", note_len); end
    press(1'b1, 1'b1);
    checks++; if (note_len !== 32'd50) begin failures++; $display("[TB] FAIL len_both_at_min got %0d required 50", note_len); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checks++; if (note_len !== 32'd100) begin failures++; $display("[TB] FAIL len_both got %0d required 100", note_len); end
    send_char(8'h6D, 66, 100, -1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (fcw != 24'd0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("[TB] FAIL len_note_start got fcw=%0d required nonzero", fcw); end
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    checks++; if (note_len !== 32'd350) begin failures++; $display("[TB] FAIL len_mid_note got %0d required 350", note_len); end
    wait_idle(ok);
    send_char(8'h76, 47, 350, -1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL len_timeout got busy=%b required idle", busy); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL len_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL len_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
    while (exp_nfcw.size() > 0) begin
      ef = exp_nfcw.pop_front(); el = exp_nlen.pop_front(); eg = exp_ngap.pop_front();
      checks++;
      if (note_rd >= note_wr) begin failures++; $display("[TB] FAIL len_note got none required fcw=%0d", ef); end
      else begin
        if (note_fcw_mem[note_rd[5:0]] !== ef || note_len_mem[note_rd[5:0]] !== el || (eg >= 0 && note_gap_mem[note_rd[5:0]] !== eg))
          begin failures++; $display("[TB] FAIL len_note got fcw=%0d len=%0d required fcw=%0d len=%0d", note_fcw_mem[note_rd[5:0]], note_len_mem[note_rd[5:0]], ef, el); end
        note_rd++;
      end
    end
  endtask

  task automatic test_reset_mid_play;
    bit ok;
    int ef, el, eg;
    logic [7:0] e8;
    // The cut-short C5 note is echoed but never completes, so no note is expected for it.
    rx_mem[rx_wr[5:0]] = 8'h2C;
    rx_wr = rx_wr + 1;
    exp_echo.push_back(8'h2C);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (fcw != 24'd0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || fcw !== 24'd70) begin failures++; $display("[TB] FAIL rst_play_start got fcw=%0d required 70", fcw); end
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fcw !== 24'd0 || note_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_async got fcw=%0d en=%b required 0/0", fcw, note_en); end
    checks++; if (note_len !== 32'd200 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_state got len=%0d busy=%b required 200/0", note_len, busy); end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_char(8'h6E, 59, 200, -1);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_recover_timeout got busy=%b required idle", busy); end
    while (exp_echo.size() > 0) begin
      e8 = exp_echo.pop_front();
      checks++;
      if (echo_rd >= echo_wr) begin failures++; $display("[TB] FAIL rst_echo got none required %h", e8); end
      else begin
        if (echo_mem[echo_rd[5:0]] !== e8) begin failures++; $display("[TB] FAIL rst_echo got %h required %h", echo_mem[echo_rd[5:0]], e8); end
        echo_rd++;
      end
    end
    while (exp_nfcw.size() > 0) begin
      ef = exp_nfcw.pop_front(); el = exp_nlen.pop_front(); eg = exp_ngap.pop_front();
      checks++;
      if (note_rd >= note_wr) begin failures++; $display("[TB] FAIL rst_note got none required fcw=%0d", ef); end
      else begin
        if (note_fcw_mem[note_rd[5:0]] !== ef || note_len_mem[note_rd[5:0]] !== el || (eg >= 0 && note_gap_mem[note_rd[5:0]] !== eg))
          begin failures++; $display("[TB] FAIL rst_note got fcw=%0d len=%0d required fcw=%0d len=%0d", note_fcw_mem[note_rd[5:0]], note_len_mem[note_rd[5:0]], ef, el); end
        note_rd++;
      end
    end
    checks++; if (note_wr !== note_rd) begin failures++; $display("[TB] FAIL rst_extra_notes got %0d required %0d", note_wr, note_rd); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_back_to_back();
    test_unmapped();
    test_tx_full();
    test_length();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
